id_ex_pipe: RTL and testbench
=============================

# id_ex_pipe

Parametrised ID→EX pipeline register with a valid/ready handshake, synchronous flush, bubble zeroing and a saturating stall counter. It sits between the decoder and the ALU, generalising the fixed-width ID/EX latch with backpressure and hazard-kill support. An optional skid entry registers `id_ready` so that the EX stall path does not reach back into ID combinationally.

## Interface
- `DATA_W`, 32: width of `reg1` and `reg2` operands.
- `ADDR_W`, 5: width of the destination register address.
- `ALUOP_W`, 8: width of the ALU op class.
- `ALUSEL_W`, 3: width of the ALU result select.
- `CNT_W`, 16: width of the stall counter.

Ports:
- `clk` in 1: sole clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: synchronous kill of all held instructions.
- `id_valid` in 1: ID presents an instruction.
- `id_ready` out 1: block accepts this cycle.
- `id_aluop` in ALUOP_W, `id_alusel` in ALUSEL_W: op class and select.
- `id_reg1` in DATA_W, `id_reg2` in DATA_W: operands.
- `id_wd` in ADDR_W, `id_wreg` in 1: destination register and write enable.
- `ex_valid` out 1: EX payload is valid.
- `ex_ready` in 1: EX consumes this cycle.
- `ex_aluop`, `ex_alusel`, `ex_reg1`, `ex_reg2`, `ex_wd`, `ex_wreg` out: payload, same widths as the `id_*` inputs.
- `stall_cnt` out CNT_W: saturating count of cycles with `ex_valid && !ex_ready`.

## Operation
- Transfer in (acc): `id_valid && id_ready && !flush`. Transfer out (pop): `ex_valid && ex_ready`.
- Main entry: drives the `ex_*` outputs.
- Occupancy states:
  - `EMPTY`: acc → `ONE`.
  - `ONE`:
    - pop && !acc → `EMPTY`.
    - pop && acc → `ONE`; main is reloaded.
    - !pop && acc → `TWO` (skid build only).
  - `TWO`:
    - pop → `ONE`; skid moves to main.
    - pop with simultaneous acc is impossible, because `id_ready`=0 in `TWO`.
- Bubble zeroing: whenever `ex_valid`=0, every payload output is forced to 0: `ex_aluop`=`EXE_NOP_OP`, `ex_alusel`=`EXE_RES_NOP`, `ex_reg1`/`ex_reg2`=`ZeroWord`, `ex_wd`=0, `ex_wreg`=`WriteDisable`. The payload registers are cleared on the transition to `EMPTY`.
- Flush:
  - Priority below `rst` and above all other events.
  - Next state is `EMPTY` with all payload zeroed.
  - Any ID presentation in the flush cycle is dropped.
  - A pop in the flush cycle still completes, because EX sampled it.
- `stall_cnt`:
  - Increments when `ex_valid && !ex_ready`.
  - Holds at 2^CNT_W−1 once saturated.
  - Cleared only by `rst`; `flush` does not clear it.
- Payload is never modified while held. When `!ex_ready`, all `ex_*` outputs stay stable.

## Timing
- `rst` (synchronous, high): the cycle after, `ex_valid`=0, all `ex_*` outputs are 0, `stall_cnt`=0, and state is `EMPTY`.
  - Without skid: `id_ready`=1 (`EMPTY`).
  - With skid: `id_ready`=1, from the registered skid flag = 0.
  - Reset mid-operation discards both entries identically.
- Latency: acc at cycle N → `ex_valid`=1 with that payload at N+1.
- Throughput: one instruction per cycle while `ex_ready`=1.
- `flush` at cycle N → `ex_valid`=0 at N+1. The earliest new instruction appears at N+2.
- `ex_valid` must not fall without a pop or flush.

## Configuration
- `ID_EX_SKID_EN` defined:
  - Adds the skid entry and the `TWO` state.
  - `id_ready` = !skid_full, driven directly from a flop with no combinational path from `ex_ready`.
  - One extra instruction is absorbed when EX stalls.
- `ID_EX_SKID_EN` undefined:
  - No skid entry and no `TWO` state.
  - `id_ready` = !ex_valid || ex_ready (combinational).
  - Maximum occupancy is 1.

## Test plan
- Reset: hold `rst`=1 for 2 cycles with random inputs → `ex_valid`=0, all `ex_*` outputs 0, `stall_cnt`=0, `id_ready`=1.
- Streaming: `ex_ready`=1, accept `reg1`=0x11, 0x22, 0x33 on consecutive cycles → `ex_reg1` shows 0x11, 0x22, 0x33 at N+1..N+3, each with `ex_valid`=1.
- Stall:
  - Setup: `ex_ready`=0 for 4 cycles while `id_valid`=1 with `wd`=3, then `wd`=4.
  - Output: `ex_wd` holds 3 and `stall_cnt` reaches 4.
  - With skid: `id_ready` drops after the second accept, and release then delivers 3 then 4.
  - Without skid: `id_ready`=0 throughout the stall.
- Flush: flush while in `TWO`/`ONE` with `id_valid`=1 → `ex_valid`=0 and `ex_wreg`=0 the next cycle, and the presented instruction is never delivered.
- Bubble: after the last pop with `id_valid`=0 → the next cycle has `ex_aluop`=`EXE_NOP_OP` and `ex_reg2`=0.
- Saturation: with CNT_W=4, stall for 20 cycles → `stall_cnt`=15 and it holds there.

Source files
------------

// File: rtl/id_ex_pipe.sv
// ID->EX pipeline register: valid/ready handshake, synchronous flush, bubble zeroing, saturating stall counter.
// Optional feature macro: ID_EX_SKID_EN adds a skid entry so id_ready is driven from a flop.
module id_ex_pipe #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ALUOP_W  = 8,
  parameter int ALUSEL_W = 3,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                id_valid,
  output logic                id_ready,
  input  logic [ALUOP_W-1:0]  id_aluop,
  input  logic [ALUSEL_W-1:0] id_alusel,
  input  logic [DATA_W-1:0]   id_reg1,
  input  logic [DATA_W-1:0]   id_reg2,
  input  logic [ADDR_W-1:0]   id_wd,
  input  logic                id_wreg,
  output logic                ex_valid,
  input  logic                ex_ready,
  output logic [ALUOP_W-1:0]  ex_aluop,
  output logic [ALUSEL_W-1:0] ex_alusel,
  output logic [DATA_W-1:0]   ex_reg1,
  output logic [DATA_W-1:0]   ex_reg2,
  output logic [ADDR_W-1:0]   ex_wd,
  output logic                ex_wreg,
  output logic [CNT_W-1:0]    stall_cnt
);

  localparam logic [ALUOP_W-1:0]  EXE_NOP_OP   = '0;
  localparam logic [ALUSEL_W-1:0] EXE_RES_NOP  = '0;
  localparam logic [DATA_W-1:0]   ZeroWord     = '0;
  localparam logic                WriteDisable = 1'b0;

  typedef struct packed {
    logic [ALUOP_W-1:0]  aluop;
    logic [ALUSEL_W-1:0] alusel;
    logic [DATA_W-1:0]   reg1;
    logic [DATA_W-1:0]   reg2;
    logic [ADDR_W-1:0]   wd;
    logic                wreg;
  } pl_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  pl_t              main_q, main_d;
  pl_t              in_pl;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_w, acc, pop;

  assign in_pl = '{aluop: id_aluop, alusel: id_alusel, reg1: id_reg1,
                   reg2: id_reg2, wd: id_wd, wreg: id_wreg};

  assign valid_w = (state_q != EMPTY);
  assign pop     = valid_w && ex_ready;
  assign acc     = id_valid && id_ready && !flush;

`ifdef ID_EX_SKID_EN
  pl_t  skid_q, skid_d;
  logic skid_full_q, skid_full_d;

  // Registered ready: EX backpressure never reaches ID combinationally.
  assign id_ready    = !skid_full_q;
  assign skid_full_d = (state_d == TWO);
`else
  assign id_ready = !valid_w || ex_ready;
`endif

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
`ifdef ID_EX_SKID_EN
    skid_d  = skid_q;
`endif
    if (flush) begin
      // A pop in this cycle still completes; everything held is discarded.
      state_d = EMPTY;
      main_d  = '0;
`ifdef ID_EX_SKID_EN
      skid_d  = '0;
`endif
    end else begin
      case (state_q)
        EMPTY: begin
          if (acc) begin
            state_d = ONE;
            main_d  = in_pl;
          end
        end
        ONE: begin
          if (pop && !acc) begin
            state_d = EMPTY;
            main_d  = '0;
          end else if (pop && acc) begin
            main_d  = in_pl;
`ifdef ID_EX_SKID_EN
          end else if (acc) begin
            state_d = TWO;
            skid_d  = in_pl;
`endif
          end
        end
`ifdef ID_EX_SKID_EN
        TWO: begin
          if (pop) begin
            state_d = ONE;
            main_d  = skid_q;
            skid_d  = '0;
          end
        end
`endif
        default: begin
          state_d = EMPTY;
          main_d  = '0;
        end
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (valid_w && !ex_ready && (cnt_q != '1))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef ID_EX_SKID_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      skid_q      <= '0;
      skid_full_q <= 1'b0;
    end else begin
      skid_q      <= skid_d;
      skid_full_q <= skid_full_d;
    end
  end
`endif

  // Bubbles present an all-zero NOP regardless of register contents.
  assign ex_valid  = valid_w;
  assign ex_aluop  = valid_w ? main_q.aluop  : EXE_NOP_OP;
  assign ex_alusel = valid_w ? main_q.alusel : EXE_RES_NOP;
  assign ex_reg1   = valid_w ? main_q.reg1   : ZeroWord;
  assign ex_reg2   = valid_w ? main_q.reg2   : ZeroWord;
  assign ex_wd     = valid_w ? main_q.wd     : '0;
  assign ex_wreg   = valid_w ? main_q.wreg   : WriteDisable;
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Self-checking bench for id_ex_pipe: directed steps plus random traffic against a queue-based model.
module tb_id_ex_pipe;
  localparam int DW = 32, AW = 5, OW = 8, SW = 3, CW = 4;
  localparam int CMAX = (1 << CW) - 1;
`ifdef ID_EX_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  typedef struct packed {
    logic [OW-1:0] op;
    logic [SW-1:0] sel;
    logic [DW-1:0] r1;
    logic [DW-1:0] r2;
    logic [AW-1:0] wd;
    logic          wreg;
  } pl_t;

  logic clk = 1'b0;
  logic rst, flush, id_valid, id_ready, ex_valid, ex_ready, ex_wreg;
  logic [OW-1:0] ex_aluop;
  logic [SW-1:0] ex_alusel;
  logic [DW-1:0] ex_reg1, ex_reg2;
  logic [AW-1:0] ex_wd;
  logic [CW-1:0] stall_cnt;
  pl_t in_p;

  int passed = 0, failed = 0, total = 0;
  pl_t q[$];
  int  m_cnt = 0;

  always #5 clk = ~clk;

  id_ex_pipe #(.DATA_W(DW), .ADDR_W(AW), .ALUOP_W(OW), .ALUSEL_W(SW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_aluop(in_p.op), .id_alusel(in_p.sel), .id_reg1(in_p.r1), .id_reg2(in_p.r2),
    .id_wd(in_p.wd), .id_wreg(in_p.wreg),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_aluop(ex_aluop), .ex_alusel(ex_alusel), .ex_reg1(ex_reg1), .ex_reg2(ex_reg2),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .stall_cnt(stall_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic pl_t rnd_p();
    pl_t p;
    p.op   = OW'($urandom);
    p.sel  = SW'($urandom);
    p.r1   = $urandom;
    p.r2   = $urandom;
    p.wd   = AW'($urandom);
    p.wreg = 1'($urandom);
    return p;
  endfunction

  // Ready as the model sees it: a capacity-limited queue; without skid a pop frees the slot same-cycle.
  function automatic bit m_rdy(input bit er);
    if (CAP == 2) return q.size() < 2;
    return (q.size() == 0) || er;
  endfunction

  // One clock: drive inputs, check outputs mid-cycle, advance the model at the edge.
  task automatic step(input bit ck, input bit r, input bit f, input bit v, input bit er, input pl_t p);
    pl_t e;
    bit  rdy;
    rst = r; flush = f; id_valid = v; ex_ready = er; in_p = p;
    @(negedge clk);
    rdy = m_rdy(er);
    if (ck) begin
      e = (q.size() > 0) ? q[0] : '0;
      chk("ex_valid", 64'(ex_valid), 64'(q.size() > 0));
      chk("id_ready", 64'(id_ready), 64'(rdy));
      chk("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
      chk("ex_reg1", 64'(ex_reg1), 64'(e.r1));
      chk("ex_reg2", 64'(ex_reg2), 64'(e.r2));
      chk("ex_ctl", 64'({ex_aluop, ex_alusel, ex_wd, ex_wreg}), 64'({e.op, e.sel, e.wd, e.wreg}));
    end
    @(posedge clk);
    if (r) begin
      q.delete();
      m_cnt = 0;
    end else begin
      if (q.size() > 0 && !er && m_cnt < CMAX) m_cnt++;
      if (q.size() > 0 && er) void'(q.pop_front());
      if (f) q.delete();
      else if (v && rdy) q.push_back(p);
    end
    #1;
  endtask

  initial begin
    pl_t p;
    // Reset with random inputs; the first cycle precedes any known state.
    step(0, 1, 1'($urandom), 1'($urandom), 1'($urandom), rnd_p());
    step(1, 1, 1'($urandom), 1'($urandom), 1'($urandom), rnd_p());
    chk("rst_valid", 64'(ex_valid), 64'(0));
    chk("rst_payload", 64'({ex_aluop, ex_alusel, ex_wd, ex_wreg} | 17'(ex_reg1 | ex_reg2)), 64'(0));
    chk("rst_cnt", 64'(stall_cnt), 64'(0));
    chk("rst_ready", 64'(id_ready), 64'(1));

    // Streaming at full rate.
    for (int i = 1; i <= 3; i++) begin
      p = rnd_p(); p.r1 = DW'(i * 'h11);
      step(1, 0, 0, 1, 1, p);
      chk("stream_valid", 64'(ex_valid), 64'(1));
      chk("stream_r1", 64'(ex_reg1), 64'(i * 'h11));
    end
    step(1, 0, 0, 0, 1, rnd_p());
    chk("bubble_valid", 64'(ex_valid), 64'(0));
    chk("bubble_op", 64'(ex_aluop), 64'(0));
    chk("bubble_r2", 64'(ex_reg2), 64'(0));

    // Stall: accept wd=3, then hold EX off for 4 cycles offering wd=4.
    p = rnd_p(); p.wd = 3;
    step(1, 0, 0, 1, 0, p);
    p = rnd_p(); p.wd = 4;
    for (int i = 0; i < 4; i++) step(1, 0, 0, 1, 0, p);
    chk("stall_wd", 64'(ex_wd), 64'(3));
    chk("stall_cnt4", 64'(stall_cnt), 64'(4));
    chk("stall_ready", 64'(id_ready), 64'(0));
    step(1, 0, 0, 0, 1, rnd_p());
`ifdef ID_EX_SKID_EN
    chk("release_wd", 64'(ex_wd), 64'(4));
    chk("release_valid", 64'(ex_valid), 64'(1));
    step(1, 0, 0, 0, 1, rnd_p());
`endif
    chk("drained", 64'(ex_valid), 64'(0));

    // Flush while full, with a fresh instruction presented.
    step(1, 0, 0, 1, 0, rnd_p());
    step(1, 0, 0, 1, 0, rnd_p());
    p = rnd_p(); p.wreg = 1;
    step(1, 0, 1, 1, 0, p);
    chk("flush_valid", 64'(ex_valid), 64'(0));
    chk("flush_wreg", 64'(ex_wreg), 64'(0));
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 1, rnd_p());
    chk("flush_dropped", 64'(ex_valid), 64'(0));

    // Counter saturation.
    step(1, 1, 0, 0, 0, rnd_p());
    step(1, 0, 0, 1, 0, rnd_p());
    for (int i = 0; i < 20; i++) step(1, 0, 0, 0, 0, rnd_p());
    chk("sat_cnt", 64'(stall_cnt), 64'(15));
    step(1, 0, 1, 0, 0, rnd_p());
    chk("sat_hold_flush", 64'(stall_cnt), 64'(15));

    // Random traffic.
    for (int i = 0; i < 400; i++)
      step(1, ($urandom_range(0, 49) == 0), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6), rnd_p());

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
